life_keyscan: RTL and testbench

Matrix-keypad scanner for the life board: the input-direction counterpart of the LED row/column display multiplexer. It drives one-hot row strobes, samples column returns, debounces each key across two consecutive scans, and emits one cell-edit event (x, y, press/release) per accepted key change through a valid/ready handshake. The grid editor consumes these events to toggle cells.

---
 rtl/life_pkg.sv | 18 +
 rtl/life_keyscan_if.sv | 14 +
 rtl/life_prio_enc.sv | 25 ++
 rtl/life_keyscan.sv | 159 +++++++++++++++
 tb/tb_life_keyscan.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Constants and the keypad scan state encoding shared by the life board's
// display multiplexer and keypad scanner.
package life_pkg;

  localparam int LIFE_X     = 8;
  localparam int LIFE_Y     = 8;
  localparam int LIFE_LOG2X = 3;
  localparam int LIFE_LOG2Y = 3;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    EMIT,
    NEXT
  } scan_state_e;

endpackage

// File: rtl/life_keyscan_if.sv
// Cell-edit event channel: one (x, y, press/release) record per valid/ready handshake.
interface life_keyscan_if #(
  parameter int LOG2X = life_pkg::LIFE_LOG2X,
  parameter int LOG2Y = life_pkg::LIFE_LOG2Y
);
  logic             ev_valid;
  logic             ev_ready;
  logic [LOG2X-1:0] ev_x;
  logic [LOG2Y-1:0] ev_y;
  logic             ev_press;

  modport master (output ev_valid, ev_x, ev_y, ev_press, input ev_ready);
  modport slave  (input ev_valid, ev_x, ev_y, ev_press, output ev_ready);
endinterface

// File: rtl/life_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus an any-set flag.
module life_prio_enc
  import life_pkg::*;
#(
  parameter int X     = LIFE_X,
  parameter int LOG2X = LIFE_LOG2X
) (
  input  logic [X-1:0]     i_vec,
  output logic [LOG2X-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_idx = '0;
    o_any = 1'b0;
    for (int i = X - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = LOG2X'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/life_keyscan.sv
// Matrix-keypad scanner with two-scan debounce and a valid/ready cell-edit event output.
// Define LIFE_KEYSCAN_RELEASE_EN to emit release events as well as presses.
module life_keyscan
  import life_pkg::*;
#(
  parameter int X      = LIFE_X,
  parameter int Y      = LIFE_Y,
  parameter int LOG2X  = LIFE_LOG2X,
  parameter int LOG2Y  = LIFE_LOG2Y,
  parameter int SETTLE = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           scan_en,
  output logic [Y-1:0]   row_drv,
  input  logic [X-1:0]   col_in,
  life_keyscan_if.master ev
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  scan_state_e      r_state;
  logic [LOG2Y-1:0] r_row;
  logic [SW-1:0]    r_settle;
  logic [X-1:0]     r_prev   [Y];
  logic [X-1:0]     r_stable [Y];
  logic [X-1:0]     r_pending;
  logic [Y-1:0]     r_row_drv;
  logic             r_ev_valid;
  logic [LOG2X-1:0] r_ev_x;
  logic [LOG2Y-1:0] r_ev_y;
  logic             r_ev_press;
`ifdef LIFE_KEYSCAN_RELEASE_EN
  logic [X-1:0]     r_sampled;
`endif

  logic [X-1:0]     w_accept;
  logic [X-1:0]     w_new_pend;
  logic [X-1:0]     w_rem;
  logic [X-1:0]     w_enc_in;
  logic [LOG2X-1:0] w_idx;
  logic             w_any;
  logic             w_take;
  logic [LOG2Y-1:0] w_next_row;

  // Accept a key change only when two consecutive scans agree and differ from the debounced state.
  assign w_accept = ~(col_in ^ r_prev[r_row]) & (col_in ^ r_stable[r_row]);
`ifdef LIFE_KEYSCAN_RELEASE_EN
  assign w_new_pend = w_accept;
`else
  assign w_new_pend = w_accept & col_in;
`endif
  assign w_rem      = r_pending & ~(X'(1) << r_ev_x);
  assign w_enc_in   = (r_state == SAMPLE) ? w_new_pend : w_rem;
  assign w_take     = r_ev_valid & ev.ev_ready;
  assign w_next_row = (r_row == LOG2Y'(Y - 1)) ? '0 : r_row + 1'b1;

  life_prio_enc #(.X(X), .LOG2X(LOG2X)) u_enc (
    .i_vec (w_enc_in),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_settle   <= '0;
      r_pending  <= '0;
      r_row_drv  <= '0;
      r_ev_valid <= 1'b0;
      r_ev_x     <= '0;
      r_ev_y     <= '0;
      r_ev_press <= 1'b0;
`ifdef LIFE_KEYSCAN_RELEASE_EN
      r_sampled  <= '0;
`endif
      // NOTE: prev/stable are flop arrays that must start as "no key held", so they are reset.
      for (int y = 0; y < Y; y++) begin
        r_prev[y]   <= '0;
        r_stable[y] <= '0;
      end
    end else begin
      // NOTE: all state updates use <= so every branch reads pre-edge values.
      case (r_state)
        IDLE: begin
          if (scan_en) begin
            r_row_drv <= Y'(1) << r_row;
            r_settle  <= '0;
            r_state   <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_settle == SW'(SETTLE - 1)) r_state <= SAMPLE;
          else                             r_settle <= r_settle + 1'b1;
        end
        SAMPLE: begin
          r_prev[r_row] <= col_in;
          r_pending     <= w_new_pend;
`ifdef LIFE_KEYSCAN_RELEASE_EN
          r_sampled     <= col_in;
`else
          r_stable[r_row] <= r_stable[r_row] & ~(w_accept & ~col_in);
`endif
          if (w_any) begin
            r_ev_valid <= 1'b1;
            r_ev_x     <= w_idx;
            r_ev_y     <= r_row;
`ifdef LIFE_KEYSCAN_RELEASE_EN
            r_ev_press <= col_in[w_idx];
`else
            r_ev_press <= 1'b1;
`endif
            r_state    <= EMIT;
          end else begin
            r_row_drv <= '0;
            r_state   <= NEXT;
          end
        end
        EMIT: begin
          if (w_take) begin
            r_stable[r_row][r_ev_x] <= ~r_stable[r_row][r_ev_x];
            r_pending               <= w_rem;
            if (w_any) begin
              r_ev_x <= w_idx;
`ifdef LIFE_KEYSCAN_RELEASE_EN
              r_ev_press <= r_sampled[w_idx];
`else
              r_ev_press <= 1'b1;
`endif
            end else begin
              r_ev_valid <= 1'b0;
              r_row_drv  <= '0;
              r_state    <= NEXT;
            end
          end
        end
        NEXT: begin
          r_row <= w_next_row;
          if (scan_en) begin
            r_row_drv <= Y'(1) << w_next_row;
            r_settle  <= '0;
            r_state   <= DRIVE;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign row_drv     = r_row_drv;
  assign ev.ev_valid = r_ev_valid;
  assign ev.ev_x     = r_ev_x;
  assign ev.ev_y     = r_ev_y;
  assign ev.ev_press = r_ev_press;

endmodule

// File: tb/tb_life_keyscan.sv
// Self-checking bench for life_keyscan: key-matrix model driving col_in from row_drv,
// a per-key debounce scoreboard, table-driven row patterns and multi-cycle corner cases.
module tb_life_keyscan;
  import life_pkg::*;

  localparam int X      = 8;
  localparam int Y      = 8;
  localparam int LX     = 3;
  localparam int LY     = 3;
  localparam int SETTLE = 4;
  localparam int FRAME  = Y * (SETTLE + 2);
`ifdef LIFE_KEYSCAN_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  typedef struct {
    int x;
    int y;
    int press;
  } ev_t;

  typedef struct {
    int           y;
    logic [X-1:0] pat;
    int           n;
    int           first;
    int           last;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         scan_en;
  logic [Y-1:0] row_drv;
  logic [X-1:0] col_in;
  logic [X-1:0] keys [Y];

  life_keyscan_if #(.LOG2X(LX), .LOG2Y(LY)) evif ();

  life_keyscan #(.X(X), .Y(Y), .LOG2X(LX), .LOG2Y(LY), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .reset   (reset),
    .scan_en (scan_en),
    .row_drv (row_drv),
    .col_in  (col_in),
    .ev      (evif)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key connects its column to the strobed row.
  always_comb begin
    col_in = '0;
    for (int y = 0; y < Y; y++) if (row_drv[y]) col_in = col_in | keys[y];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Scoreboard state: last raw value and debounced value per key, expected event queue.
  logic [X-1:0] m_prev   [Y];
  logic [X-1:0] m_stable [Y];
  logic [Y-1:0] m_prev_rd;
  int           m_row;
  ev_t          exp_q [$];
  ev_t          got_q [$];
  bit           hold_pending;
  ev_t          hold_ev;

  task automatic scan_row(input logic [Y-1:0] rd);
    int r;
    logic [X-1:0] v;
    r = 0;
    for (int y = 0; y < Y; y++) if (rd[y]) r = y;
    check("row_onehot", 32'($onehot(rd)), 1);
    check("row_order", r, m_row);
    v = keys[r];
    for (int x = 0; x < X; x++) begin
      if (v[x] == m_prev[r][x] && v[x] != m_stable[r][x]) begin
        m_stable[r][x] = v[x];
        if (REL || v[x]) exp_q.push_back('{x, r, int'(v[x])});
      end
    end
    m_prev[r] = v;
    m_row = (r + 1) % Y;
  endtask

  task automatic take_event();
    ev_t g, e;
    g = '{int'(evif.ev_x), int'(evif.ev_y), int'(evif.ev_press)};
    got_q.push_back(g);
    check("event_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ev_x", g.x, e.x);
      check("ev_y", g.y, e.y);
      check("ev_press", g.press, e.press);
    end
  endtask

  initial begin
    m_prev_rd = '0;
    m_row = 0;
    hold_pending = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int y = 0; y < Y; y++) begin
          m_prev[y]   = '0;
          m_stable[y] = '0;
        end
        exp_q.delete();
        m_prev_rd = '0;
        m_row = 0;
        hold_pending = 0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", 32'(evif.ev_valid), 1);
          check("hold_x", 32'(evif.ev_x), hold_ev.x);
          check("hold_y", 32'(evif.ev_y), hold_ev.y);
          check("hold_press", 32'(evif.ev_press), hold_ev.press);
        end
        if (m_prev_rd == '0 && row_drv != '0) scan_row(row_drv);
        m_prev_rd = row_drv;
        hold_pending = evif.ev_valid && !evif.ev_ready;
        hold_ev = '{int'(evif.ev_x), int'(evif.ev_y), int'(evif.ev_press)};
        if (evif.ev_valid && evif.ev_ready) take_event();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_gap();
    int k = 0;
    while (row_drv != '0 && k < 100) begin tick(1); k++; end
    check("gap_timeout", 32'(row_drv == '0), 1);
  endtask

  task automatic wait_row(input int r);
    int k = 0;
    while (row_drv != (Y'(1) << r) && k < 4 * FRAME) begin tick(1); k++; end
    check("row_timeout", 32'(row_drv == (Y'(1) << r)), 1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!evif.ev_valid && k < 4 * FRAME) begin tick(1); k++; end
    check("valid_timeout", 32'(evif.ev_valid), 1);
  endtask

  task automatic set_row(input int y, input logic [X-1:0] pat);
    wait_gap();
    keys[y] = pat;
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_row_drv"}, 32'(row_drv), 0);
    check({tag, "_valid"}, 32'(evif.ev_valid), 0);
    check({tag, "_x"}, 32'(evif.ev_x), 0);
    check({tag, "_y"}, 32'(evif.ev_y), 0);
    check({tag, "_press"}, 32'(evif.ev_press), 0);
  endtask

  vec_t vecs [4];

  initial begin
    int base, cnt;
    vecs[0] = '{5, 8'h08, 1, 3, 3};
    vecs[1] = '{0, 8'h81, 2, 0, 7};
    vecs[2] = '{7, 8'hFF, 8, 0, 7};
    vecs[3] = '{2, 8'h50, 2, 4, 6};

    reset = 1'b0;
    scan_en = 1'b0;
    evif.ev_ready = 1'b0;
    for (int y = 0; y < Y; y++) keys[y] = '0;
    tick(3);
    check_outputs_reset("por");
    reset = 1'b1;
    tick(2);
    check("idle_row_drv", 32'(row_drv), 0);
    scan_en = 1'b1;
    evif.ev_ready = 1'b1;

    // Table: press a row pattern, hold it, then release it.
    for (int i = 0; i < 4; i++) begin
      base = got_q.size();
      set_row(vecs[i].y, vecs[i].pat);
      tick(3 * FRAME + 40);
      cnt = got_q.size() - base;
      check("tbl_press_count", cnt, vecs[i].n);
      if (cnt == vecs[i].n) begin
        check("tbl_first_x", got_q[base].x, vecs[i].first);
        check("tbl_last_x", got_q[base + cnt - 1].x, vecs[i].last);
        check("tbl_y", got_q[base].y, vecs[i].y);
        check("tbl_press", got_q[base].press, 1);
      end
      base = got_q.size();
      set_row(vecs[i].y, '0);
      tick(3 * FRAME + 40);
      check("tbl_release_count", got_q.size() - base, REL ? vecs[i].n : 0);
    end

    // Re-press (3,5) after its release.
    base = got_q.size();
    set_row(5, 8'h08);
    tick(3 * FRAME + 40);
    check("repress_count", got_q.size() - base, 1);
    if (got_q.size() > base) check("repress_press", got_q[base].press, 1);
    set_row(5, '0);
    tick(3 * FRAME + 40);

    // Single-scan glitch on (2,1) yields nothing.
    base = got_q.size();
    wait_row(0);
    wait_gap();
    keys[1][2] = 1'b1;
    wait_row(1);
    wait_gap();
    keys[1][2] = 1'b0;
    tick(2 * FRAME + 20);
    check("glitch_count", got_q.size() - base, 0);

    // Back-pressure: (1,4) and (6,4) with ev_ready low for 10 cycles.
    evif.ev_ready = 1'b0;
    set_row(4, 8'h42);
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(evif.ev_valid), 1);
      check("bp_x", 32'(evif.ev_x), 1);
      check("bp_y", 32'(evif.ev_y), 4);
      check("bp_row_drv", 32'(row_drv), 32'h10);
      tick(1);
    end
    evif.ev_ready = 1'b1;
    tick(1);
    check("bp_second_valid", 32'(evif.ev_valid), 1);
    check("bp_second_x", 32'(evif.ev_x), 6);
    check("bp_second_y", 32'(evif.ev_y), 4);
    check("bp_second_row_drv", 32'(row_drv), 32'h10);
    tick(1);
    check("bp_done_valid", 32'(evif.ev_valid), 0);
    set_row(4, '0);
    tick(3 * FRAME + 40);

    // scan_en dropped mid-EMIT: finish the row, stop, then resume on the following row.
    evif.ev_ready = 1'b0;
    set_row(2, 8'hA1);
    wait_valid();
    check("drop_y", 32'(evif.ev_y), 2);
    scan_en = 1'b0;
    base = got_q.size();
    evif.ev_ready = 1'b1;
    tick(3);
    check("drop_delivered", got_q.size() - base, 3);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (row_drv != '0) cnt++;
    end
    check("drop_idle_strobes", cnt, 0);
    scan_en = 1'b1;
    tick(1);
    cnt = 0;
    while (row_drv == '0 && cnt < 10) begin tick(1); cnt++; end
    check("resume_row", 32'(row_drv), 32'h08);
    set_row(2, '0);
    tick(3 * FRAME + 40);

    // Reset while an event is waiting: outputs clear at once, event dropped.
    evif.ev_ready = 1'b0;
    set_row(6, 8'h04);
    wait_valid();
    reset = 1'b0;
    #1;
    check_outputs_reset("rst_emit");
    for (int y = 0; y < Y; y++) keys[y] = '0;
    tick(2);
    check_outputs_reset("rst_hold");
    reset = 1'b1;
    evif.ev_ready = 1'b1;
    tick(2 * FRAME);
    check("post_reset_queue", exp_q.size(), 0);

    // Random key activity against the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      int ry, rx;
      evif.ev_ready = ($urandom % 4) != 0;
      scan_en = ($urandom % 16) != 0;
      if (row_drv == '0 && ($urandom % 6) == 0) begin
        ry = $urandom_range(Y - 1);
        rx = $urandom_range(X - 1);
        keys[ry][rx] = ~keys[ry][rx];
      end
      tick(1);
    end
    scan_en = 1'b1;
    evif.ev_ready = 1'b1;
    tick(3 * FRAME + 200);
    check("random_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
